// File: rtl/irq_aff_pkg.sv
// Shared constants for the FPGA-to-HPS interrupt affinity router:
// CSR word offsets, route field width and parameter limits.
package irq_aff_pkg;

  localparam int unsigned ROUTE_W = 5;
  localparam int unsigned MAX_SRC = 32;
  localparam int unsigned MAX_TGT = 32;

  localparam logic [5:0] REG_PENDING    = 6'h00;
  localparam logic [5:0] REG_ENABLE     = 6'h01;
  localparam logic [5:0] REG_MODE       = 6'h02;
  localparam logic [5:0] REG_SWTRIG     = 6'h03;
  localparam logic [5:0] REG_ACTIVE     = 6'h04;
  localparam logic [5:0] REG_ROUTE_BASE = 6'h08;

endpackage

// File: rtl/irq_src_cond.sv
// One interrupt source conditioner: synchroniser, rising-edge detect and
// the pending bit (level follows the source, edge latches until W1C).
module irq_src_cond #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic mode_i,
  input  logic sw_set_i,
  input  logic w1c_i,
  output logic pending_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   pending_q;
  logic                   pending_d;
  logic                   s;
  logic                   rise;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  // Set terms are ORed after the clear so a coincident set wins.
  always_comb begin
    pending_d = s;
    if (mode_i) begin
      pending_d = (pending_q & ~w1c_i) | rise | sw_set_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      s_d_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], src_i};
      s_d_q     <= s;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/irq_affinity_router.sv
// Routes NUM_SRC conditioned interrupt sources onto NUM_TGT f2h_irq lines,
// with per-source enable, mode and target selected through an Avalon-MM CSR block.
module irq_affinity_router
  import irq_aff_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned NUM_TGT     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [5:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  output logic [NUM_TGT-1:0] irq_out
);

  logic [NUM_SRC-1:0]              enable_q, enable_d;
  logic [NUM_SRC-1:0]              mode_q, mode_d;
  logic [NUM_SRC-1:0][ROUTE_W-1:0] route_q, route_d;
  logic [NUM_TGT-1:0]              irq_q, irq_d;
  logic [31:0]                     rdata_q, rdata_d;
  logic [NUM_SRC-1:0]              pending;
  logic [NUM_SRC-1:0]              sw_set;
  logic [NUM_SRC-1:0]              w1c;
  logic [NUM_SRC-1:0]              wdata_src;
  logic [5:0]                      route_idx;
  logic                            route_sel;
  logic                            unused_wdata;

  assign wdata_src    = avs_writedata[NUM_SRC-1:0];
  assign route_idx    = avs_address - REG_ROUTE_BASE;
  assign route_sel    = (avs_address >= REG_ROUTE_BASE);
  assign unused_wdata = ^avs_writedata;

  assign w1c    = (avs_write && avs_address == REG_PENDING) ? wdata_src : '0;
  assign sw_set = (avs_write && avs_address == REG_SWTRIG) ? wdata_src : '0;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_src_cond #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cond (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .src_i    (irq_src[i]),
      .mode_i   (mode_q[i]),
      .sw_set_i (sw_set[i]),
      .w1c_i    (w1c[i]),
      .pending_o(pending[i])
    );
  end

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    route_d  = route_q;
    if (avs_write) begin
      case (avs_address)
        REG_ENABLE: enable_d = wdata_src;
        REG_MODE:   mode_d   = wdata_src;
        default: begin
          for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (route_sel && route_idx == 6'(i)) begin
              route_d[i] = avs_writedata[ROUTE_W-1:0];
            end
          end
        end
      endcase
    end
  end

  // Reads see the registered (pre-write) state, so a same-cycle W1C is not visible.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      rdata_d = '0;
      case (avs_address)
        REG_PENDING: rdata_d = 32'(pending);
        REG_ENABLE:  rdata_d = 32'(enable_q);
        REG_MODE:    rdata_d = 32'(mode_q);
        REG_ACTIVE:  rdata_d = 32'(pending & enable_q);
        default: begin
          for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (route_sel && route_idx == 6'(i)) begin
              rdata_d = 32'(route_q[i]);
            end
          end
        end
      endcase
    end
  end

  // Out-of-range route values never match a target and so drive no line.
  always_comb begin
    irq_d = '0;
    for (int unsigned t = 0; t < NUM_TGT; t++) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (pending[i] && enable_q[i] && route_q[i] == ROUTE_W'(t)) begin
          irq_d[t] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= '0;
      mode_q   <= '0;
      route_q  <= '0;
      irq_q    <= '0;
      rdata_q  <= '0;
    end else begin
      enable_q <= enable_d;
      mode_q   <= mode_d;
      route_q  <= route_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq_out      = irq_q;

endmodule
